snn_neuron_scheduler: RTL and testbench

Time-multiplexed scheduler that shares one leaky-integrate-and-fire (LIF) update datapath among `N_NEURONS` virtual neurons. It holds per-neuron membrane potential, threshold and refractory state. On each `tick` it runs one network timestep by walking the neurons in index order. It sits between the chip's input pins, which supply the input current, and the output spike vector that drives `uo_out`.

---
 rtl/snn_pkg.sv | 26 ++
 rtl/lif_update.sv | 49 ++++
 rtl/snn_neuron_scheduler.sv | 159 +++++++++++++++
 tb/tb_snn_neuron_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and defaults for the time-multiplexed LIF neuron scheduler.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_N_NEURONS  = 4;
  localparam int DEFAULT_W          = 8;
  localparam int DEFAULT_LEAK_SHIFT = 3;
  localparam int DEFAULT_REFRACT    = 2;
  localparam int DEFAULT_THRESH     = 100;

  // Unsigned add clipped to max_val; the carry bit keeps the compare exact.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_val}) ? max_val : s[31:0];
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky-integrate-and-fire step for one neuron: leak, integrate,
// saturate, threshold compare and refractory countdown.
module lif_update
  import snn_pkg::*;
#(
  parameter int W          = DEFAULT_W,
  parameter int LEAK_SHIFT = DEFAULT_LEAK_SHIFT,
  parameter int REFRACT    = DEFAULT_REFRACT,
  parameter int RW         = 2
) (
  input  logic [W-1:0]  v,
  input  logic [W-1:0]  cur,
  input  logic [W-1:0]  thresh,
  input  logic [RW-1:0] refr,
  output logic [W-1:0]  v_next,
  output logic [RW-1:0] refr_next,
  output logic          spike
);

  localparam logic [31:0] V_MAX = (32'd1 << W) - 32'd1;

  logic [W-1:0]  leaked;
  logic [31:0]   sum_full;
  logic [W-1:0]  sum;
  logic [31-W:0] unused_sum_hi;

  assign leaked        = v - (v >> LEAK_SHIFT);
  assign sum_full      = sat_add(32'(leaked), 32'(cur), V_MAX);
  assign sum           = sum_full[W-1:0];
  assign unused_sum_hi = sum_full[31:W];

  always_comb begin
    v_next    = '0;
    refr_next = '0;
    spike     = 1'b0;
    if (refr != '0) begin
      refr_next = refr - RW'(1);
    end else if (thresh == '0) begin
      // a zero threshold parks the neuron: potential held at 0, never fires
      v_next = '0;
    end else if (sum >= thresh) begin
      spike     = 1'b1;
      refr_next = RW'(REFRACT);
    end else begin
      v_next = sum;
    end
  end

endmodule

// File: rtl/snn_neuron_scheduler.sv
// Shares one LIF datapath across N_NEURONS virtual neurons; each tick walks
// the neurons in index order, two cycles per neuron.
//
//   state  | meaning
//   IDLE   | waiting for tick
//   LOAD   | present cur_idx, capture current and neuron state
//   UPDATE | write back potential/refractory, record spike bit
//   DONE   | spikes valid, done pulse, return to IDLE
module snn_neuron_scheduler
  import snn_pkg::*;
#(
  parameter int N_NEURONS  = DEFAULT_N_NEURONS,
  parameter int W          = DEFAULT_W,
  parameter int LEAK_SHIFT = DEFAULT_LEAK_SHIFT,
  parameter int REFRACT    = DEFAULT_REFRACT,
  parameter int DEF_THRESH = DEFAULT_THRESH,
  localparam int IW        = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 cfg_we,
  input  logic [IW-1:0]        cfg_addr,
  input  logic [W-1:0]         cfg_thresh,
  output logic [IW-1:0]        cur_idx,
  input  logic [W-1:0]         cur_in,
  output logic [N_NEURONS-1:0] spikes,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

  state_t state_q, state_d;

  logic [IW-1:0] idx_q;
  logic          last_idx;

  logic [W-1:0]  v_mem      [N_NEURONS];
  logic [W-1:0]  thresh_mem [N_NEURONS];
  logic [RW-1:0] refr_mem   [N_NEURONS];

  logic [W-1:0]  v_r, cur_r, thresh_r;
  logic [RW-1:0] refr_r;

  logic [W-1:0]  v_upd;
  logic [RW-1:0] refr_upd;
  logic          spike_upd;

  logic [N_NEURONS-1:0] spk_next, spk_merged, spikes_q;
  logic                 overrun_q;

  assign last_idx = (idx_q == IW'(N_NEURONS - 1));

  lif_update #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT),
    .RW         (RW)
  ) u_lif (
    .v         (v_r),
    .cur       (cur_r),
    .thresh    (thresh_r),
    .refr      (refr_r),
    .v_next    (v_upd),
    .refr_next (refr_upd),
    .spike     (spike_upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    cur_idx = '0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (tick) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cur_idx = idx_q;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        cur_idx = idx_q;
        state_d = last_idx ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The last neuron's spike is merged in directly so spikes is already
  // current in the cycle that done is high.
  always_comb begin
    spk_merged         = spk_next;
    spk_merged[idx_q]  = spike_upd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      v_r       <= '0;
      cur_r     <= '0;
      thresh_r  <= '0;
      refr_r    <= '0;
      spk_next  <= '0;
      spikes_q  <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]      <= '0;
        thresh_mem[i] <= W'(DEF_THRESH);
        refr_mem[i]   <= '0;
      end
    end else begin
      if (tick && (state_q != ST_IDLE)) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (tick) idx_q <= '0;
        end
        ST_LOAD: begin
          cur_r    <= cur_in;
          v_r      <= v_mem[idx_q];
          thresh_r <= thresh_mem[idx_q];
          refr_r   <= refr_mem[idx_q];
        end
        ST_UPDATE: begin
          v_mem[idx_q]    <= v_upd;
          refr_mem[idx_q] <= refr_upd;
          spk_next[idx_q] <= spike_upd;
          if (last_idx) spikes_q <= spk_merged;
          else          idx_q    <= idx_q + IW'(1);
        end
        ST_DONE: begin
          idx_q <= '0;
        end
        default: ;
      endcase

      // LOAD reads thresh_mem with the pre-edge value, so a same-edge write
      // only reaches the next capture of that neuron.
      if (cfg_we) thresh_mem[cfg_addr] <= cfg_thresh;
    end
  end

  assign spikes  = spikes_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
// Scoreboard bench for snn_neuron_scheduler: a behavioural LIF model predicts
// each timestep's spike vector and done cycle; a monitor checks on done.
module tb_snn_neuron_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_thresh = '0;
  logic [IW-1:0] cur_idx;
  logic [W-1:0]  cur_in;
  logic [N-1:0]  spikes;
  logic          busy, done, overrun;

  logic [W-1:0]  cur_tab [N];
  assign cur_in = cur_tab[cur_idx];

  snn_neuron_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_thresh (cfg_thresh),
    .cur_idx    (cur_idx),
    .cur_in     (cur_in),
    .spikes     (spikes),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  int m_v    [N];
  int m_th   [N];
  int m_refr [N];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i]    = 0;
      m_refr[i] = 0;
      m_th[i]   = 100;
    end
  endfunction

  function automatic logic [N-1:0] model_step();
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      int sum;
      if (m_refr[i] > 0) begin
        m_v[i]    = 0;
        m_refr[i] = m_refr[i] - 1;
      end else if (m_th[i] == 0) begin
        m_v[i] = 0;
      end else begin
        sum = m_v[i] - m_v[i] / 8 + int'(cur_tab[i]);
        if (sum > 255) sum = 255;
        if (sum >= m_th[i]) begin
          s[i]      = 1'b1;
          m_v[i]    = 0;
          m_refr[i] = 2;
        end else begin
          m_v[i] = sum;
        end
      end
    end
    return s;
  endfunction

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [N-1:0] spk;
    int           cyc;
  } exp_t;

  exp_t sb_q [$];
  int   idx_seq [$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      idx_seq.delete();
    end else if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("spikes", int'(spikes), int'(mon_e.spk));
        check("done_cycle", cyc, mon_e.cyc);
        check("cur_idx_at_done", int'(cur_idx), 0);
        check("cur_idx_seq_len", idx_seq.size(), 2 * N);
        for (int k = 0; k < idx_seq.size() && k < 2 * N; k++)
          check("cur_idx_seq", idx_seq[k], k / 2);
      end
      idx_seq.delete();
    end else if (busy) begin
      idx_seq.push_back(int'(cur_idx));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
    cur_tab[0] = W'(c0);
    cur_tab[1] = W'(c1);
    cur_tab[2] = W'(c2);
    cur_tab[3] = W'(c3);
  endtask

  task automatic cfg_write(input int addr, input int val);
    cfg_we     = 1'b1;
    cfg_addr   = IW'(addr);
    cfg_thresh = W'(val);
    @(negedge clk);
    cfg_we     = 1'b0;
    m_th[addr] = val;
  endtask

  // Entered at a negedge with cyc=P; tick is sampled at the edge to P+1, so
  // done is expected at cyc=P+2N+1 and the FSM is idle again at P+2N+2.
  task automatic do_tick(input bit race, input int race_val, input bit ovr);
    exp_t e;
    tick  = 1'b1;
    e.cyc = cyc + 2 * N + 1;
    e.spk = model_step();
    sb_q.push_back(e);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    if (race) begin
      // lands on the edge closing neuron 0's UPDATE
      cfg_we     = 1'b1;
      cfg_addr   = '0;
      cfg_thresh = W'(race_val);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    if (race) m_th[0] = race_val;
    if (ovr) tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2 * N - 2) @(negedge clk);
    check("busy_idle_after_step", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    set_cur(0, 0, 0, 0);
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_spikes", int'(spikes), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_cur_idx", int'(cur_idx), 0);

    // leak, spike, refractory on neuron 0
    set_cur(60, 0, 0, 0);
    repeat (5) do_tick(1'b0, 0, 1'b0);

    // saturation on neuron 1
    cfg_write(1, 255);
    set_cur(0, 200, 0, 0);
    repeat (2) do_tick(1'b0, 0, 1'b0);

    // neuron 2 disabled
    cfg_write(2, 0);
    set_cur(0, 0, 255, 0);
    repeat (5) do_tick(1'b0, 0, 1'b0);

    // threshold write racing neuron 0's UPDATE
    set_cur(50, 0, 0, 0);
    do_tick(1'b1, 20, 1'b0);
    do_tick(1'b0, 0, 1'b0);
    do_tick(1'b0, 0, 1'b0);
    check("overrun_still_clear", int'(overrun), 0);

    // randomized traffic
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) cur_tab[i] = W'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 7) == 0) cfg_write(int'($urandom_range(0, N - 1)), 0);
        else cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 255)));
      end
      do_tick($urandom_range(0, 4) == 0, int'($urandom_range(1, 255)), 1'b0);
    end

    // overrun: tick pulsed in cycle 3 of a timestep
    set_cur(10, 20, 30, 40);
    do_tick(1'b0, 0, 1'b1);
    check("overrun_set", int'(overrun), 1);
    do_tick(1'b0, 0, 1'b0);
    check("overrun_sticky", int'(overrun), 1);

    // asynchronous reset mid-timestep
    set_cur(200, 200, 200, 200);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_spikes", int'(spikes), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_overrun", int'(overrun), 0);
    check("async_rst_cur_idx", int'(cur_idx), 0);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", sb_q.size(), 0);

    set_cur(0, 0, 0, 0);
    do_tick(1'b0, 0, 1'b0);
    // neuron 2's threshold is back at its default after reset
    set_cur(0, 0, 100, 0);
    do_tick(1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
